// File: rtl/seg7_time_display.sv
// ---------------------------------------------------------------------------
// seg7_time_display
//   Drives the BASYS3 4-digit common-anode 7-segment display with the
//   2-digit BCD seconds value from the Counter time_reading bus, by
//   time-multiplexed scanning.
//   - One coherent sample of time_reading is latched per scan frame.
//   - The tens digit is blanked when zero (BLANK_LZ=1).
//   - An invalid BCD nibble is shown as a dash.
//   - The display blinks while counting is paused.
//
// Ports
//   clk            in   1  system clock
//   init_regs      in   1  synchronous reset, active-high
//   count_enabled  in   1  1 = running (steady), 0 = paused (blink)
//   time_reading   in   8  [7:4] tens BCD, [3:0] ones BCD
//   an             out  4  digit anodes, active-low
//   seg            out  7  {g,f,e,d,c,b,a}, active-low
//   dp             out  1  decimal point, active-low, constant 1
//   frame_sync     out  1  1-cycle pulse when a new sample is latched
// ---------------------------------------------------------------------------
module seg7_time_display #(
  parameter int CLK_FREQ   = 100000000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int BLANK_LZ   = 1
) (
  input  logic       clk,
  input  logic       init_regs,
  input  logic       count_enabled,
  input  logic [7:0] time_reading,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_sync
);

  localparam int DIGIT_TICKS = CLK_FREQ / REFRESH_HZ;
  localparam int HALF_BLINK  = CLK_FREQ / (2 * BLINK_HZ);
  localparam int TICK_W      = $clog2(DIGIT_TICKS);
  localparam int BLINK_W     = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF_BLINK - 1);

  typedef enum logic [1:0] {
    SLOT_ONES   = 2'd0,
    SLOT_TENS   = 2'd1,
    SLOT_BLANK2 = 2'd2,
    SLOT_BLANK3 = 2'd3
  } slot_t;

  logic [TICK_W-1:0]  tick;
  slot_t              slot;
  slot_t              slot_next;
  logic [7:0]         shown;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  logic               tick_wrap;
  logic               latch;
  logic               display_on;
  logic [3:0]         an_next;
  logic [6:0]         seg_next;

  // Active-low segment pattern for one BCD nibble; non-BCD shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = 7'h3F;
    endcase
    return pattern;
  endfunction

  // Slot sequencing and frame latch strobe.
  always_comb begin
    slot_next = slot;
    tick_wrap = (tick == TICK_LAST);
    latch     = tick_wrap && (slot == SLOT_BLANK3);
    if (tick_wrap) begin
      case (slot)
        SLOT_ONES:   slot_next = SLOT_TENS;
        SLOT_TENS:   slot_next = SLOT_BLANK2;
        SLOT_BLANK2: slot_next = SLOT_BLANK3;
        default:     slot_next = SLOT_ONES;
      endcase
    end
  end

  // Next an/seg pair, computed together so both change on the same edge.
  // count_enabled overrides blink_on directly so resuming lights the
  // display on the very next cycle.
  always_comb begin
    an_next    = 4'hF;
    seg_next   = 7'h7F;
    display_on = blink_on || count_enabled;
    if (display_on) begin
      case (slot)
        SLOT_ONES: begin
          an_next  = 4'b1110;
          seg_next = decode(shown[3:0]);
        end
        SLOT_TENS: begin
          if (!((BLANK_LZ != 0) && (shown[7:4] == 4'd0))) begin
            an_next  = 4'b1101;
            seg_next = decode(shown[7:4]);
          end
        end
        default: begin
          an_next  = 4'hF;
          seg_next = 7'h7F;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (init_regs) begin
      tick       <= '0;
      slot       <= SLOT_ONES;
      shown      <= 8'h00;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      an         <= 4'hF;
      seg        <= 7'h7F;
      frame_sync <= 1'b0;
    end else begin
      tick       <= tick_wrap ? '0 : tick + TICK_W'(1);
      slot       <= slot_next;
      frame_sync <= latch;
      an         <= an_next;
      seg        <= seg_next;
      if (latch) begin
        shown <= time_reading;
      end
      if (count_enabled) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign dp = 1'b1;

endmodule
